// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter sequencer: FSM state encoding,
// the idle control code and the default parameter widths.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PHASE_A = 2'd1,
        PHASE_B = 2'd2,
        FINISH  = 2'd3
    } seq_state_t;

    localparam logic [1:0] CTRL_IDLE = 2'b00;

    localparam int DEFAULT_N  = 4;
    localparam int DEFAULT_DW = 8;
    localparam int DEFAULT_LW = 4;

endpackage

// File: rtl/counter_sequencer_if.sv
// Sequencer bus: configuration and request inputs, observed counter value,
// and the control/status outputs. The slave side is the sequencer itself.
interface counter_sequencer_if
    import counter_seq_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int DW = DEFAULT_DW,
    parameter int LW = DEFAULT_LW
);

    logic          start;
    logic          stop;
    logic [1:0]    mode_a;
    logic [1:0]    mode_b;
    logic [DW-1:0] dwell_a;
    logic [DW-1:0] dwell_b;
    logic [LW-1:0] loops;
    logic          match_en;
    logic [N-1:0]  match_val;
    logic [N-1:0]  cnt_in;
    logic [1:0]    ctrl;
    logic          busy;
    logic          phase;
    logic          done;
    logic          aborted;

    modport master (
        output start, stop, mode_a, mode_b, dwell_a, dwell_b, loops,
               match_en, match_val, cnt_in,
        input  ctrl, busy, phase, done, aborted
    );

    modport slave (
        input  start, stop, mode_a, mode_b, dwell_a, dwell_b, loops,
               match_en, match_val, cnt_in,
        output ctrl, busy, phase, done, aborted
    );

endinterface

// File: rtl/dwell_timer.sv
// Loadable down-counter that times one phase. Loading value v makes expire
// rise after v further cycles, so a phase of length L is loaded with L-1.
// The count stops at zero instead of wrapping.
module dwell_timer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic          expire
);

    logic [DW-1:0] count;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/counter_sequencer.sv
// Counter sequencer: on start, latches a program and drives ctrl with mode_a
// for dwell_a cycles, then mode_b for dwell_b cycles, repeating for the
// programmed number of loops (forever when loops is zero). Stop aborts back
// to IDLE, a latched match on cnt_in finishes early. All outputs are
// registered and reflect the state entered on the same edge.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int DW = DEFAULT_DW,
    parameter int LW = DEFAULT_LW
) (
    input logic                  clk,
    input logic                  reset,
    counter_sequencer_if.slave   bus
);

    generate
        if (N < 2) begin : g_bad_n
            $error("counter_sequencer: N must be at least 2");
        end
    endgenerate

    seq_state_t    state_q, state_d;

    logic [1:0]    mode_a_q, mode_b_q;
    logic [DW-1:0] dwell_a_q, dwell_b_q;
    logic [LW-1:0] loops_q;
    logic          match_en_q;
    logic [N-1:0]  match_val_q;
    logic          latch_cfg;

    logic [LW-1:0] loop_q, loop_d;
    logic [LW:0]   loop_inc;
    logic          last_loop;

    logic          timer_load;
    logic [DW-1:0] timer_val;
    logic          timer_expire;

    logic          match_hit;

    logic [1:0]    ctrl_q, ctrl_d;
    logic          busy_q, busy_d;
    logic          phase_q, phase_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;

    // A dwell of zero behaves like one, so the timer is loaded with max(d,1)-1.
    function automatic logic [DW-1:0] dwell_to_load(input logic [DW-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    dwell_timer #(.DW(DW)) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (timer_expire)
    );

    assign match_hit = match_en_q && (bus.cnt_in == match_val_q);
    assign loop_inc  = {1'b0, loop_q} + {{LW{1'b0}}, 1'b1};
    assign last_loop = (loops_q != '0) && (loop_inc == {1'b0, loops_q});

    // Next-state, timer/loop control and next registered outputs.
    always_comb begin
        state_d    = state_q;
        loop_d     = loop_q;
        latch_cfg  = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;
        aborted_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d    = PHASE_A;
                    latch_cfg  = 1'b1;
                    loop_d     = '0;
                    timer_load = 1'b1;
                    timer_val  = dwell_to_load(bus.dwell_a);
                end
            end
            PHASE_A: begin
                if (bus.stop) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (match_hit) begin
                    state_d = FINISH;
                end else if (timer_expire) begin
                    state_d    = PHASE_B;
                    timer_load = 1'b1;
                    timer_val  = dwell_to_load(dwell_b_q);
                end
            end
            PHASE_B: begin
                if (bus.stop) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (match_hit) begin
                    state_d = FINISH;
                end else if (timer_expire) begin
                    if (last_loop) begin
                        state_d = FINISH;
                    end else begin
                        state_d    = PHASE_A;
                        timer_load = 1'b1;
                        timer_val  = dwell_to_load(dwell_a_q);
                        if (loop_q != '1) begin
                            loop_d = loop_inc[LW-1:0];
                        end
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            PHASE_A: ctrl_d = latch_cfg ? bus.mode_a : mode_a_q;
            PHASE_B: ctrl_d = mode_b_q;
            default: ctrl_d = CTRL_IDLE;
        endcase
        busy_d  = (state_d == PHASE_A) || (state_d == PHASE_B);
        phase_d = (state_d == PHASE_B);
        done_d  = (state_d == FINISH);
    end

    // State, loop counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            loop_q    <= '0;
            ctrl_q    <= CTRL_IDLE;
            busy_q    <= 1'b0;
            phase_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            loop_q    <= loop_d;
            ctrl_q    <= ctrl_d;
            busy_q    <= busy_d;
            phase_q   <= phase_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Program latch; only loaded on an accepted start, so it is frozen during a run.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_a_q    <= '0;
            mode_b_q    <= '0;
            dwell_a_q   <= '0;
            dwell_b_q   <= '0;
            loops_q     <= '0;
            match_en_q  <= 1'b0;
            match_val_q <= '0;
        end else if (latch_cfg) begin
            mode_a_q    <= bus.mode_a;
            mode_b_q    <= bus.mode_b;
            dwell_a_q   <= bus.dwell_a;
            dwell_b_q   <= bus.dwell_b;
            loops_q     <= bus.loops;
            match_en_q  <= bus.match_en;
            match_val_q <= bus.match_val;
        end
    end

    assign bus.ctrl    = ctrl_q;
    assign bus.busy    = busy_q;
    assign bus.phase   = phase_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed testbench for counter_sequencer with hand-computed ctrl sequences.
module tb_counter_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    counter_sequencer_if #(.N(4), .DW(8), .LW(4)) bus ();

    counter_sequencer #(.N(4), .DW(8), .LW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic expectOutputs(input string tag, input logic [1:0] c, input logic b,
                                 input logic p, input logic d, input logic a);
        checkOutput({tag, ".ctrl"},    32'(bus.ctrl),    32'(c));
        checkOutput({tag, ".busy"},    32'(bus.busy),    32'(b));
        checkOutput({tag, ".phase"},   32'(bus.phase),   32'(p));
        checkOutput({tag, ".done"},    32'(bus.done),    32'(d));
        checkOutput({tag, ".aborted"}, 32'(bus.aborted), 32'(a));
    endtask

    task automatic checkPhaseRun(input string tag, input logic [1:0] mode,
                                 input logic ph, input int n);
        for (int i = 0; i < n; i++) begin
            expectOutputs($sformatf("%s[%0d]", tag, i), mode, 1'b1, ph, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ma, input logic [7:0] da,
                                 input logic [1:0] mb, input logic [7:0] db,
                                 input logic [3:0] lp, input logic men,
                                 input logic [3:0] mval);
        bus.mode_a    = ma;
        bus.dwell_a   = da;
        bus.mode_b    = mb;
        bus.dwell_b   = db;
        bus.loops     = lp;
        bus.match_en  = men;
        bus.match_val = mval;
    endtask

    task automatic startSeq();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.cnt_in = '0;
        applyStimulus(2'b00, 8'd0, 2'b00, 8'd0, 4'd0, 1'b0, 4'd0);

        // Reset held for two cycles.
        tick();
        tick();
        expectOutputs("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expectOutputs("idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Normal two-loop sequence.
        applyStimulus(2'b01, 8'd3, 2'b11, 8'd2, 4'd2, 1'b0, 4'd0);
        startSeq();
        checkPhaseRun("norm.a0", 2'b01, 1'b0, 3);
        checkPhaseRun("norm.b0", 2'b11, 1'b1, 2);
        checkPhaseRun("norm.a1", 2'b01, 1'b0, 3);
        checkPhaseRun("norm.b1", 2'b11, 1'b1, 2);
        expectOutputs("norm.fin", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expectOutputs("norm.idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Stop at cycle 7 with endless looping.
        applyStimulus(2'b01, 8'd3, 2'b11, 8'd2, 4'd0, 1'b0, 4'd0);
        startSeq();
        checkPhaseRun("stop.a0", 2'b01, 1'b0, 3);
        checkPhaseRun("stop.b0", 2'b11, 1'b1, 2);
        checkPhaseRun("stop.a1", 2'b01, 1'b0, 1);
        expectOutputs("stop.c7", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        expectOutputs("stop.abort", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expectOutputs("stop.after", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Early match on the latched target, input target changed mid-run.
        applyStimulus(2'b01, 8'd10, 2'b11, 8'd2, 4'd0, 1'b1, 4'd5);
        bus.cnt_in = 4'd0;
        startSeq();
        expectOutputs("match.a", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.match_val = 4'd7;
        bus.cnt_in    = 4'd5;
        tick();
        expectOutputs("match.fin", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.cnt_in = 4'd0;
        tick();
        expectOutputs("match.idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Zero dwell lengths behave as one cycle each.
        applyStimulus(2'b01, 8'd0, 2'b11, 8'd0, 4'd1, 1'b0, 4'd0);
        startSeq();
        checkPhaseRun("zero.a", 2'b01, 1'b0, 1);
        checkPhaseRun("zero.b", 2'b11, 1'b1, 1);
        expectOutputs("zero.fin", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expectOutputs("zero.idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start during PHASE_B is ignored and new config is not picked up.
        applyStimulus(2'b01, 8'd3, 2'b11, 8'd2, 4'd1, 1'b0, 4'd0);
        startSeq();
        checkPhaseRun("ign.a", 2'b01, 1'b0, 3);
        expectOutputs("ign.b0", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b10, 8'd9, 2'b01, 8'd9, 4'd3, 1'b0, 4'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expectOutputs("ign.b1", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expectOutputs("ign.fin", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expectOutputs("ign.idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start together with stop in IDLE does nothing.
        applyStimulus(2'b01, 8'd3, 2'b11, 8'd2, 4'd1, 1'b0, 4'd0);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        expectOutputs("ss.0", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expectOutputs("ss.1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in PHASE_A overrides a simultaneous stop and match.
        applyStimulus(2'b01, 8'd3, 2'b11, 8'd2, 4'd0, 1'b1, 4'd9);
        bus.cnt_in = 4'd0;
        startSeq();
        expectOutputs("rst.a", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.cnt_in = 4'd9;
        bus.stop   = 1'b1;
        reset      = 1'b1;
        tick();
        expectOutputs("rst.in", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset      = 1'b0;
        bus.stop   = 1'b0;
        bus.cnt_in = 4'd0;
        tick();
        expectOutputs("rst.out", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter N, default 4, width of the observed counter value; N >= 2 SHALL be enforced.
REQ-002 Parameter DW, default 8, width of the dwell-length inputs.
REQ-003 Parameter LW, default 4, width of the loop-count input.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 start  input  1  one-cycle request to begin a programmed sequence.
REQ-007 stop  input  1  abort request, level-sampled each cycle.
REQ-008 mode_a, mode_b  input  2 each  ctrl codes driven in phase A and phase B.
REQ-009 dwell_a, dwell_b  input  DW each  phase lengths in cycles; 0 SHALL be treated as 1.
REQ-010 loops  input  LW  number of A->B repetitions; 0 = repeat until stop or match.
REQ-011 match_en  input  1; match_val  input  N: early-termination enable and target value.
REQ-012 cnt_in  input  N  value observed from the controlled counter's output.
REQ-013 ctrl  output  2  registered control code for the counter.
REQ-014 busy  output  1  high in PHASE_A and PHASE_B.
REQ-015 phase  output  1  0 = phase A, 1 = phase B; 0 when not busy.
REQ-016 done, aborted  output  1 each  one-cycle completion and abort pulses.

Function
REQ-017 The FSM SHALL have states IDLE, PHASE_A, PHASE_B and FINISH.
REQ-018 In IDLE and FINISH, ctrl SHALL equal CTRL_IDLE (2'b00).
REQ-019 Start in IDLE with stop low SHALL latch all configuration inputs, and from the next edge the block SHALL output ctrl = mode_a, state PHASE_A.
REQ-020 Latched configuration SHALL be immune to input changes until the block returns to IDLE.
REQ-021 Each phase SHALL last exactly max(dwell,1) cycles, then hand over: A->B, or B->A when loops remain.
REQ-022 After the B phase of loop number loops (loops != 0), the block SHALL enter FINISH for one cycle with done = 1, then return to IDLE.
REQ-023 Match rule: match_en = 1 and cnt_in == match_val while busy SHALL take the next edge to FINISH (done = 1).
REQ-024 Stop while busy SHALL take the next edge to IDLE with ctrl = CTRL_IDLE and aborted = 1 for one cycle; done SHALL stay 0.
REQ-025 Priority, highest first: reset, stop, match, dwell expiry.
REQ-026 Start while busy or in FINISH SHALL be ignored.
REQ-027 Start and stop together in IDLE: the block SHALL remain in IDLE with no pulse.
REQ-028 Loop and dwell counters SHALL not wrap; the loop counter saturates when loops = 0.

Reset
REQ-029 On reset: state IDLE, ctrl = 2'b00, busy = 0, phase = 0, done = 0, aborted = 0, and all counters and latched configuration zero.
REQ-030 Reset mid-sequence SHALL override stop and match, and produce no done or aborted pulse.

Structure
REQ-031 Package counter_seq_pkg SHALL hold the state enum, CTRL_IDLE, and the default N, DW and LW.
REQ-032 Phase timing SHALL use one sub-module, dwell_timer: a DW-bit loadable down-counter with an expire output.

Verification
REQ-033 Reset: reset = 1 for 2 cycles -> all outputs zero.
REQ-034 Normal sequence: start, mode_a = 01, dwell_a = 3, mode_b = 11, dwell_b = 2, loops = 2 -> ctrl = 01,01,01,11,11,01,01,01,11,11, then a 00 cycle with done = 1, then IDLE.
REQ-035 Stop mid-run: loops = 0, stop at cycle 7 -> ctrl = 00 from the next edge, aborted = 1 for one cycle, done = 0.
REQ-036 Early match: match_en = 1, match_val = 5, cnt_in reaches 5 in phase A -> FINISH next edge, done = 1.
REQ-037 Zero dwell: dwell_a = 0, dwell_b = 0, loops = 1 -> 01 for 1 cycle, 11 for 1 cycle, then done.
REQ-038 Ignored requests: start during PHASE_B is ignored; start with stop in IDLE keeps busy = 0; reset in PHASE_A zeroes outputs with no pulses.
